mem_stage: RTL

//  Memory-access stage; consumes the registered E->M bundle (RegWriteM..breakM) and drives the data-memory bus.

---
 rtl/mem_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives the data-memory bus, stalls upstream while the bus is busy,
// aborts a stuck access after TIMEOUT_CYC wait cycles. Optional macro MEM_ALIGN_CHECK_EN flags misaligned word accesses.
module mem_stage #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic        MemWriteSBM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    input  logic [31:0] PCPlus4M,
    input  logic        JalM,
    input  logic        sysM,
    input  logic        breakM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic        JalW,
    output logic        sysW,
    output logic        breakW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteRegW,
    output logic [31:0] PCPlus4W,
    output logic        bus_err_W,
    output logic        align_err_W
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      stateReg;
    logic [7:0]  countReg;

    logic        isByteStore;
    logic        isWordStore;
    logic        isLoad;
    logic        access;
    logic        misaligned;
    logic        busReq;
    logic        timeoutHit;
    logic        stall;

    // Priority: byte store over word store over load.
    assign isByteStore = MemWriteSBM;
    assign isWordStore = MemWriteM & ~MemWriteSBM;
    assign isLoad      = MemtoRegM & ~MemWriteM & ~MemWriteSBM;
    assign access      = MemtoRegM | MemWriteM | MemWriteSBM;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (isLoad | isWordStore) & (ALUOutM[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign busReq     = access & ~misaligned;
    assign timeoutHit = (stateReg == S_WAIT) & ~dmem_ready
                        & (countReg == 8'(TIMEOUT_CYC - 1));
    assign stall      = busReq & ~dmem_ready & ~timeoutHit;

    // Gated by rst_n so the request drops the instant reset is applied.
    assign dmem_req   = rst_n & busReq;
    assign StallM     = rst_n & stall;
    assign dmem_we    = isByteStore | isWordStore;
    assign dmem_addr  = {ALUOutM[31:2], 2'b00};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign dmem_be[gi] = isByteStore ? (ALUOutM[1:0] == 2'(gi)) : 1'b1;
            assign dmem_wdata[8*gi +: 8] = isByteStore ? WriteDataM[7:0]
                                                       : WriteDataM[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg    <= S_IDLE;
            countReg    <= 8'd0;
            RegWriteW   <= 1'b0;
            MemtoRegW   <= 1'b0;
            JalW        <= 1'b0;
            sysW        <= 1'b0;
            breakW      <= 1'b0;
            ReadDataW   <= 32'd0;
            ALUOutW     <= 32'd0;
            WriteRegW   <= 5'd0;
            PCPlus4W    <= 32'd0;
            bus_err_W   <= 1'b0;
            align_err_W <= 1'b0;
        end else begin
            case (stateReg)
                S_IDLE: begin
                    if (busReq && !dmem_ready) begin
                        stateReg <= S_WAIT;
                        countReg <= 8'd0;
                    end
                end
                S_WAIT: begin
                    if (dmem_ready || timeoutHit) begin
                        stateReg <= S_IDLE;
                    end else begin
                        countReg <= countReg + 8'd1;
                    end
                end
                default: stateReg <= S_IDLE;
            endcase

            if (timeoutHit || stall) begin
                // Bubble into writeback; a timeout additionally raises the error pulse.
                RegWriteW   <= 1'b0;
                MemtoRegW   <= 1'b0;
                JalW        <= 1'b0;
                sysW        <= 1'b0;
                breakW      <= 1'b0;
                bus_err_W   <= timeoutHit;
                align_err_W <= 1'b0;
            end else begin
                RegWriteW   <= RegWriteM & ~misaligned;
                MemtoRegW   <= MemtoRegM;
                JalW        <= JalM;
                sysW        <= sysM;
                breakW      <= breakM;
                ReadDataW   <= (isLoad && !misaligned) ? dmem_rdata : 32'd0;
                ALUOutW     <= ALUOutM;
                WriteRegW   <= WriteRegM;
                PCPlus4W    <= PCPlus4M;
                bus_err_W   <= 1'b0;
                align_err_W <= misaligned;
            end
        end
    end

endmodule
